vend_ctrl: RTL
==============

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE0, default 100, price of product 0 in cents.
REQ-002 Parameter PRICE1, default 150, price of product 1 in cents.
REQ-003 Parameter PRICE2, default 75, price of product 2 in cents.
REQ-004 Parameter PRICE3, default 200, price of product 3 in cents.
REQ-005 Parameter MAX_CREDIT, default 250, credit ceiling in cents (<=255).
REQ-006 Parameter TIMEOUT_S, default 30, idle seconds in COLLECT before auto-refund.
REQ-007 Parameter HOLD_S, default 2, seconds in HOLD after a transaction.
REQ-008 The block SHALL use one clock and a synchronous, active-low reset: clk  in  1  system clock; rst_n  in  1  synchronous active-low reset.
REQ-009 sec_clk  in  1  1 Hz square wave from divider, clk-synchronous level.
REQ-010 coin_valid  in  1  one-cycle coin-inserted strobe.
REQ-011 coin_code  in  2  00=5, 01=25, 10=50, 11=100 cents.
REQ-012 sel_valid  in  1  one-cycle product-select strobe.
REQ-013 sel_id  in  2  selected product.
REQ-014 cancel  in  1  one-cycle cancel strobe.
REQ-015 credit  out  8  current credit in cents.
REQ-016 dispense  out  1  one-cycle vend strobe; dispense_id  out  2  product vended.
REQ-017 change_valid  out  1  one-cycle refund strobe; change_amt  out  8  cents returned.
REQ-018 coin_reject  out  1  one-cycle strobe, coin returned unaccepted.
REQ-019 sel_nack  out  1  one-cycle strobe, selection refused (insufficient credit).
REQ-020 state  out  3  current FSM state encoding.

Function
REQ-021 All outputs SHALL be registered; strobe outputs assert for exactly one clk cycle.
REQ-022 FSM states SHALL be IDLE, COLLECT, VEND, REFUND, HOLD.
REQ-023 A second tick SHALL be one cycle at each sec_clk rising edge, detected against its registered previous value.
REQ-024 IDLE/COLLECT: accepted coin in cycle N SHALL update credit at N+1 and enter/stay COLLECT.
REQ-025 A coin making credit exceed MAX_CREDIT SHALL be rejected (coin_reject at N+1, credit unchanged).
REQ-026 Coins in VEND, REFUND or HOLD SHALL be rejected.
REQ-027 COLLECT, sel_valid with credit>=price: VEND at N+1, dispense=1, dispense_id=sel_id.
REQ-028 COLLECT, sel_valid with credit<price: sel_nack at N+1, stay COLLECT, credit unchanged.
REQ-029 sel_valid in IDLE SHALL produce sel_nack; sel_valid/cancel in VEND/REFUND/HOLD SHALL be ignored.
REQ-030 VEND lasts one cycle; next state REFUND if credit-price>0, else HOLD.
REQ-031 REFUND lasts one cycle with change_valid=1, change_amt=remaining credit; then HOLD.
REQ-032 Credit SHALL read 0 from HOLD entry onward.
REQ-033 cancel in COLLECT SHALL go REFUND with full credit; cancel in IDLE ignored.
REQ-034 Same-cycle priority: cancel > sel_valid > coin_valid; the losing coin is rejected.
REQ-035 Inactivity counter clears on entry to COLLECT and on each accepted coin or sel_nack; increments per second tick.
REQ-036 When the counter reaches TIMEOUT_S in COLLECT, the next state SHALL be REFUND with full credit.
REQ-037 HOLD SHALL exit to IDLE after HOLD_S second ticks (counter cleared on HOLD entry).
REQ-038 Tick coincident with a resetting event: the clear wins.

Reset
REQ-039 rst_n=0 at a clk edge SHALL force IDLE, credit=0, all strobes 0, change_amt=0, dispense_id=0, counters and edge register cleared, mid-transaction included; no refund is issued.

Structure
REQ-040 Package vend_pkg SHALL hold the state enum, coin_code-to-cents constants and default prices.
REQ-041 Sub-module vend_sec_timer SHALL hold the sec_clk edge detector and clearable seconds counter.

Verification
REQ-042 Reset, coins 100+50, select 1 -> dispense=1 id=1, no change_valid, HOLD, IDLE after 2 ticks.
REQ-043 Coins 100+100, select 2 -> dispense id=2, next cycle change_valid with change_amt=125.
REQ-044 Coin 50, select 0 -> sel_nack, credit 50; cancel -> change_valid, change_amt=50.
REQ-045 Credit 200, coin 100 -> coin_reject, credit stays 200; cancel+select+coin same cycle -> refund 200, coin_reject.
REQ-046 Coin 25, 30 sec_clk edges no activity -> change_valid, change_amt=25; coin at tick 29 restarts count.
REQ-047 rst_n low during VEND -> IDLE, credit 0, no change_valid.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// Holds the FSM state enum, coin_code-to-cents mapping and default prices/timing.
package vend_pkg;

  localparam int unsigned CREDIT_W = 8;
  localparam int unsigned SEC_W    = 8;

  // Coin denominations in cents, indexed by coin_code
  localparam int unsigned COIN_5_C   = 5;
  localparam int unsigned COIN_25_C  = 25;
  localparam int unsigned COIN_50_C  = 50;
  localparam int unsigned COIN_100_C = 100;

  localparam int unsigned DEF_PRICE0     = 100;
  localparam int unsigned DEF_PRICE1     = 150;
  localparam int unsigned DEF_PRICE2     = 75;
  localparam int unsigned DEF_PRICE3     = 200;
  localparam int unsigned DEF_MAX_CREDIT = 250;
  localparam int unsigned DEF_TIMEOUT_S  = 30;
  localparam int unsigned DEF_HOLD_S     = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_VEND    = 3'd2,
    ST_REFUND  = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  function automatic logic [CREDIT_W-1:0] coin_cents(input logic [1:0] code);
    case (code)
      2'b00:   return CREDIT_W'(COIN_5_C);
      2'b01:   return CREDIT_W'(COIN_25_C);
      2'b10:   return CREDIT_W'(COIN_50_C);
      default: return CREDIT_W'(COIN_100_C);
    endcase
  endfunction

endpackage

// File: rtl/vend_sec_timer.sv
// Seconds timer: detects sec_clk rising edges and counts them in a clearable,
// saturating counter.
// Ports: clk, rst_n (sync active-low), sec_clk_i (1 Hz level), clr_i (clear),
//        secs_o (registered seconds count).
module vend_sec_timer
  import vend_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sec_clk_i,
  input  logic             clr_i,
  output logic [SEC_W-1:0] secs_o
);

  logic             sec_q;
  logic [SEC_W-1:0] cnt_q;
  logic             tick_c;

  assign tick_c = sec_clk_i & ~sec_q;
  assign secs_o = cnt_q;

  // Clear takes precedence over a coincident tick; count saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sec_q <= sec_clk_i;
      if (clr_i) begin
        cnt_q <= '0;
      end else if (tick_c && (cnt_q != {SEC_W{1'b1}})) begin
        cnt_q <= cnt_q + SEC_W'(1);
      end
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: accumulates coin credit, vends on selection,
// returns change, refunds on cancel or inactivity timeout.
// Ports: clk, rst_n (sync active-low), sec_clk (1 Hz level), coin_valid/coin_code,
//        sel_valid/sel_id, cancel in; credit, dispense/dispense_id,
//        change_valid/change_amt, coin_reject, sel_nack, state out (all registered).
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0     = DEF_PRICE0,
  parameter int unsigned PRICE1     = DEF_PRICE1,
  parameter int unsigned PRICE2     = DEF_PRICE2,
  parameter int unsigned PRICE3     = DEF_PRICE3,
  parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int unsigned TIMEOUT_S  = DEF_TIMEOUT_S,
  parameter int unsigned HOLD_S     = DEF_HOLD_S
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_clk,
  input  logic       coin_valid,
  input  logic [1:0] coin_code,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  output logic [7:0] credit,
  output logic       dispense,
  output logic [1:0] dispense_id,
  output logic       change_valid,
  output logic [7:0] change_amt,
  output logic       coin_reject,
  output logic       sel_nack,
  output logic [2:0] state
);

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                dispense_q;
  logic [1:0]          disp_id_q;
  logic                chg_valid_q;
  logic [CREDIT_W-1:0] chg_amt_q;
  logic                reject_q;
  logic                nack_q;

  logic [SEC_W-1:0]    secs;
  logic                tmr_clr;
  logic [CREDIT_W-1:0] cents_c;
  logic [CREDIT_W-1:0] price_c;
  logic                coin_fits_c;
  logic                acc_coin;
  logic                do_nack;
  logic                do_vend;
  logic                do_refund;

  vend_sec_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .sec_clk_i (sec_clk),
    .clr_i     (tmr_clr),
    .secs_o    (secs)
  );

  assign cents_c     = coin_cents(coin_code);
  assign coin_fits_c = ({1'b0, credit_q} + {1'b0, cents_c}) <= (CREDIT_W + 1)'(MAX_CREDIT);

  // Price of the currently selected product
  always_comb begin
    case (sel_id)
      2'd0:    price_c = CREDIT_W'(PRICE0);
      2'd1:    price_c = CREDIT_W'(PRICE1);
      2'd2:    price_c = CREDIT_W'(PRICE2);
      default: price_c = CREDIT_W'(PRICE3);
    endcase
  end

  // Event decode with priority cancel > select > coin > timeout
  always_comb begin
    acc_coin  = 1'b0;
    do_nack   = 1'b0;
    do_vend   = 1'b0;
    do_refund = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid)                      do_nack  = 1'b1;
        else if (coin_valid && coin_fits_c) acc_coin = 1'b1;
      end
      ST_COLLECT: begin
        if (cancel) begin
          do_refund = 1'b1;
        end else if (sel_valid) begin
          if (credit_q >= price_c) do_vend = 1'b1;
          else                     do_nack = 1'b1;
        end else if (coin_valid && coin_fits_c) begin
          acc_coin = 1'b1;
        end else if (secs >= SEC_W'(TIMEOUT_S)) begin
          do_refund = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Clear the seconds counter on activity and on every entry to COLLECT or HOLD
  assign tmr_clr = acc_coin | do_nack | (state_q == ST_REFUND) |
                   ((state_q == ST_VEND) && (credit_q == '0));

  // Main FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      credit_q    <= '0;
      dispense_q  <= 1'b0;
      disp_id_q   <= 2'd0;
      chg_valid_q <= 1'b0;
      chg_amt_q   <= '0;
      reject_q    <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      dispense_q  <= 1'b0;
      chg_valid_q <= 1'b0;
      reject_q    <= coin_valid & ~acc_coin;
      nack_q      <= do_nack;
      case (state_q)
        ST_IDLE: begin
          if (acc_coin) begin
            credit_q <= credit_q + cents_c;
            state_q  <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (do_refund) begin
            chg_valid_q <= 1'b1;
            chg_amt_q   <= credit_q;
            credit_q    <= '0;
            state_q     <= ST_REFUND;
          end else if (do_vend) begin
            dispense_q <= 1'b1;
            disp_id_q  <= sel_id;
            credit_q   <= credit_q - price_c;
            state_q    <= ST_VEND;
          end else if (acc_coin) begin
            credit_q <= credit_q + cents_c;
          end
        end
        ST_VEND: begin
          // credit_q already holds the change owed
          if (credit_q != '0) begin
            chg_valid_q <= 1'b1;
            chg_amt_q   <= credit_q;
            credit_q    <= '0;
            state_q     <= ST_REFUND;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        ST_REFUND: state_q <= ST_HOLD;
        ST_HOLD: begin
          if (secs >= SEC_W'(HOLD_S)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign dispense_id  = disp_id_q;
  assign change_valid = chg_valid_q;
  assign change_amt   = chg_amt_q;
  assign coin_reject  = reject_q;
  assign sel_nack     = nack_q;

endmodule
